pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for a five-stage in-order core.
//
// Generates the per-stage register enables, bubble inserts and PC control
// from the hazard inputs, and sequences single-step and HALT draining.
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous active-low reset
//   step_mode        1 = single-step, 0 = free-run
//   step_pulse       one-cycle advance request used in single-step
//   id_rs, id_rt     source fields of the ID instruction
//   id_uses_rt       ID instruction reads rt
//   id_halt          ID instruction is HALT
//   ex_rt            destination field of the EX instruction
//   ex_memread       EX instruction is a load
//   ex_branch_taken  EX resolved a taken branch
//   pc_en, pc_load   PC enable / load branch target
//   if_id_en/_flush  IF/ID enable / bubble insert
//   id_ex_en/_flush  ID/EX enable / bubble insert
//   ex_mem_en        EX/MEM enable
//   mem_wb_en        MEM/WB enable
//   halted           pipeline frozen after HALT
//   state            RUN=0, STEP=1, DRAIN=2, HALTED=3
//   stall_cnt        saturating count of load-use bubbles
//   flush_cnt        saturating count of taken-branch flushes
module pipe_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        step_mode,
  input  logic        step_pulse,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_halt,
  input  logic [4:0]  ex_rt,
  input  logic        ex_memread,
  input  logic        ex_branch_taken,
  output logic        pc_en,
  output logic        pc_load,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        halted,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_STEP   = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  drain_q, drain_d;
  logic [15:0] stall_q, stall_d;
  logic [15:0] flush_q, flush_d;

  logic advance;
  logic load_use;
  logic do_stall;
  logic do_flush;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ex_rt==0 is the hard-wired zero register, so it never creates a hazard.
  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    advance = 1'b0;
    unique case (state_q)
      ST_RUN:   advance = 1'b1;
      ST_STEP:  advance = step_pulse;
      // DRAIN obeys whichever mode is currently selected.
      ST_DRAIN: advance = step_mode ? step_pulse : 1'b1;
      default:  advance = 1'b0;
    endcase
  end

  // Hazards only apply while instructions are still entering the pipe.
  assign do_flush = advance && ((state_q == ST_RUN) || (state_q == ST_STEP)) &&
                    ex_branch_taken;
  assign do_stall = advance && ((state_q == ST_RUN) || (state_q == ST_STEP)) &&
                    load_use && !ex_branch_taken;

  always_comb begin
    pc_en       = 1'b0;
    pc_load     = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if (advance) begin
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (state_q == ST_DRAIN) begin
        // Freeze fetch and feed bubbles behind the HALT so older
        // instructions complete.
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
      end else if (ex_branch_taken) begin
        pc_en       = 1'b1;
        pc_load     = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID one cycle; a single bubble enters ID/EX.
        id_ex_flush = 1'b1;
      end else begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    stall_d = do_stall ? sat_inc(stall_q) : stall_q;
    flush_d = do_flush ? sat_inc(flush_q) : flush_q;
    unique case (state_q)
      ST_RUN, ST_STEP: begin
        if (advance && id_halt && !load_use && !ex_branch_taken) begin
          state_d = ST_DRAIN;
          drain_d = 2'd0;
        end else if ((state_q == ST_RUN) && step_mode) begin
          state_d = ST_STEP;
        end else if ((state_q == ST_STEP) && !step_mode) begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (advance) begin
          if (drain_q == 2'd2) begin
            state_d = ST_HALTED;
            drain_d = 2'd0;
          end else begin
            drain_d = drain_q + 2'd1;
          end
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      drain_q <= 2'd0;
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign halted    = (state_q == ST_HALTED);
  assign state     = state_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl with a behavioural reference
// model checked every cycle, plus literal expectations at key points.
module tb_pipe_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        step_mode, step_pulse;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_halt, ex_memread, ex_branch_taken;
  logic        pc_en, pc_load, if_id_en, if_id_flush;
  logic        id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, halted;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  bit running = 1'b0;

  pipe_ctrl dut (
    .clock(clock), .reset(reset), .step_mode(step_mode), .step_pulse(step_pulse),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_halt(id_halt),
    .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en), .pc_load(pc_load), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .halted(halted), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // m_st uses the published state numbering; m_left counts remaining
  // drain advances.
  int m_st, m_left, m_stall, m_flush;

  function automatic bit m_hazard();
    return ex_memread && (ex_rt != 0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

  function automatic bit m_adv(input int st);
    if (st == 0) return 1'b1;
    if (st == 1) return step_pulse;
    if (st == 2) return step_mode ? step_pulse : 1'b1;
    return 1'b0;
  endfunction

  // {pc_en,pc_load,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mem_en,mem_wb_en}
  function automatic logic [7:0] m_ctl(input int st);
    if (!m_adv(st))       return 8'b0000_0000;
    if (st == 2)          return 8'b0011_1011;
    if (ex_branch_taken)  return 8'b1111_1111;
    if (m_hazard())       return 8'b0000_1111;
    return 8'b1010_1011;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_st <= 0; m_left <= 0; m_stall <= 0; m_flush <= 0;
    end else begin
      if (m_st <= 1) begin
        if (m_adv(m_st) && ex_branch_taken)
          m_flush <= (m_flush < 65535) ? m_flush + 1 : m_flush;
        if (m_adv(m_st) && !ex_branch_taken && m_hazard())
          m_stall <= (m_stall < 65535) ? m_stall + 1 : m_stall;
        if (m_adv(m_st) && id_halt && !ex_branch_taken && !m_hazard()) begin
          m_st <= 2; m_left <= 3;
        end else if (m_st == 0 && step_mode) m_st <= 1;
        else if (m_st == 1 && !step_mode) m_st <= 0;
      end else if (m_st == 2 && m_adv(m_st)) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_st <= 3;
      end
    end
  end

  logic [42:0] act_v, exp_v;
  assign act_v = {pc_en, pc_load, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                  ex_mem_en, mem_wb_en, halted, state, stall_cnt, flush_cnt};

  always @(negedge clock) begin
    if (running) begin
      exp_v = {m_ctl(m_st), (m_st == 3), 2'(m_st), 16'(m_stall), 16'(m_flush)};
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL cycle_model t=%0t actual=%h expected=%h", $time, act_v, exp_v);
      end
    end
  end

  // ---------------- literal checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    step_pulse = 0; id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 0; id_halt = 0;
    ex_rt = 5'd3; ex_memread = 0; ex_branch_taken = 0;
  endtask

  int en_cycles;

  initial begin
    reset = 0; step_mode = 0;
    idle_inputs();
    running = 1'b1;
    repeat (3) tick();
    @(negedge clock);
    check("reset_state", 32'(state), 0);
    check("reset_halted", 32'(halted), 0);
    check("reset_stall", 32'(stall_cnt), 0);
    check("reset_flush", 32'(flush_cnt), 0);
    reset = 1;
    repeat (2) tick();

    // load-use on rs
    ex_memread = 1; ex_rt = 5'd5; id_rs = 5'd5;
    @(negedge clock);
    check("lu_pc_en", 32'(pc_en), 0);
    check("lu_if_id_en", 32'(if_id_en), 0);
    check("lu_id_ex_flush", 32'(id_ex_flush), 1);
    tick(); idle_inputs();
    @(negedge clock);
    check("lu_stall_cnt", 32'(stall_cnt), 1);
    check("lu_one_bubble_pc_en", 32'(pc_en), 1);
    tick();

    // r0 never hazards
    ex_memread = 1; ex_rt = 5'd0; id_rs = 5'd0;
    @(negedge clock);
    check("r0_pc_en", 32'(pc_en), 1);
    tick(); idle_inputs();
    @(negedge clock);
    check("r0_stall_cnt", 32'(stall_cnt), 1);
    tick();

    // load-use through rt, with and without id_uses_rt
    ex_memread = 1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1;
    tick();
    id_uses_rt = 0;
    @(negedge clock);
    check("rt_unused_pc_en", 32'(pc_en), 1);
    tick(); idle_inputs();
    @(negedge clock);
    check("rt_stall_cnt", 32'(stall_cnt), 2);
    tick();

    // taken branch beats load-use
    ex_memread = 1; ex_rt = 5'd5; id_rs = 5'd5; ex_branch_taken = 1;
    @(negedge clock);
    check("br_pc_load", 32'(pc_load), 1);
    check("br_if_id_flush", 32'(if_id_flush), 1);
    check("br_id_ex_flush", 32'(id_ex_flush), 1);
    check("br_pc_en", 32'(pc_en), 1);
    tick(); idle_inputs();
    @(negedge clock);
    check("br_flush_cnt", 32'(flush_cnt), 1);
    check("br_stall_cnt", 32'(stall_cnt), 2);
    tick();

    // HALT ignored under branch and under load-use
    id_halt = 1; ex_branch_taken = 1;
    tick();
    ex_branch_taken = 0; ex_memread = 1; ex_rt = 5'd1;
    tick(); idle_inputs();
    @(negedge clock);
    check("halt_blocked_state", 32'(state), 0);
    tick();

    // single-step: three pulses five cycles apart
    step_mode = 1;
    tick();
    en_cycles = 0;
    for (int i = 0; i < 15; i++) begin
      step_pulse = (i % 5 == 0);
      @(negedge clock);
      if (pc_en | if_id_en | id_ex_en | ex_mem_en | mem_wb_en) en_cycles++;
      tick();
    end
    step_pulse = 0;
    check("step_en_cycles", 32'(en_cycles), 3);
    check("step_state", 32'(state), 1);
    step_mode = 0;
    tick();

    // free-run HALT drain
    id_halt = 1;
    @(negedge clock);
    check("halt_issue_pc_en", 32'(pc_en), 1);
    tick(); idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("drain_state", 32'(state), 2);
      check("drain_pc_en", 32'(pc_en), 0);
      tick();
    end
    step_pulse = 1;
    @(negedge clock);
    check("halted_state", 32'(state), 3);
    check("halted_flag", 32'(halted), 1);
    check("halted_enables", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 0);
    tick(); step_pulse = 0;
    reset = 0;
    @(negedge clock);
    check("post_reset_state", 32'(state), 0);
    check("post_reset_halted", 32'(halted), 0);
    tick(); reset = 1;
    tick();

    // step-mode drain, aborted by reset, then completed
    step_mode = 1;
    tick();
    step_pulse = 1; id_halt = 1;
    tick(); idle_inputs();
    repeat (4) tick();
    step_pulse = 1; tick(); step_pulse = 0; tick();
    step_pulse = 1; tick(); step_pulse = 0;
    reset = 0; tick(); reset = 1;
    tick();
    step_pulse = 1; id_halt = 1;
    tick(); idle_inputs();
    for (int i = 0; i < 2; i++) begin
      step_pulse = 1; tick(); step_pulse = 0; tick();
    end
    @(negedge clock);
    check("step_drain_not_done", 32'(state), 2);
    step_pulse = 1; tick(); step_pulse = 0;
    @(negedge clock);
    check("step_drain_halted", 32'(state), 3);
    reset = 0; tick(); reset = 1; step_mode = 0;
    tick();

    // stall counter saturation
    ex_memread = 1; ex_rt = 5'd9; id_rs = 5'd9;
    repeat (70000) tick();
    idle_inputs();
    @(negedge clock);
    check("stall_saturate", 32'(stall_cnt), 32'h0000FFFF);
    tick();

    running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
